// File: rtl/audio_pkg.sv
// Shared audio-path definitions: low-pass coefficients, volume level, dequantize and FIR states.
// AUDIO_FIR_VOLUME_EN adds the StVolume state used by audio_fir_decim.
package audio_pkg;

    localparam int unsigned AUDIO_DATA_SIZE = 32;
    localparam int unsigned AUDIO_QUANT     = 10;
    localparam int unsigned AUDIO_LPR_TAPS  = 32;

    // Q10 gain applied after the MAC when the volume stage is built in (2048 = x2.0).
    localparam logic signed [AUDIO_DATA_SIZE-1:0] VOLUME_LEVEL = 32'sd2048;

    // Symmetric Q10 low-pass taps; tap 0 sits in the least-significant word.
    localparam logic [AUDIO_LPR_TAPS*AUDIO_DATA_SIZE-1:0] AUDIO_LPR_COEFFS = {
        -32'sd1,  -32'sd2,  -32'sd3,  -32'sd3,  32'sd0,   32'sd5,   32'sd11,  32'sd15,
        32'sd13,  32'sd3,   -32'sd13, -32'sd28, -32'sd30, -32'sd10, 32'sd36,  32'sd98,
        32'sd98,  32'sd36,  -32'sd10, -32'sd30, -32'sd28, -32'sd13, 32'sd3,   32'sd13,
        32'sd15,  32'sd11,  32'sd5,   32'sd0,   -32'sd3,  -32'sd3,  -32'sd2,  -32'sd1
    };

    // Signed dequantize, truncating toward zero rather than toward minus infinity.
    function automatic logic signed [63:0] dequantize(input logic signed [63:0] v,
                                                      input int unsigned      q);
        if (v < 0) begin
            return -((-v) >>> q);
        end
        return v >>> q;
    endfunction

`ifdef AUDIO_FIR_VOLUME_EN
    typedef enum logic [1:0] {StLoad, StMac, StWrite, StVolume} fir_state_e;
`else
    typedef enum logic [1:0] {StLoad, StMac, StWrite} fir_state_e;
`endif

endpackage

// File: rtl/sample_shift_reg.sv
// Tap delay line for the audio FIR: shifts din into tap 0 on shift_en and
// presents the tap selected by rd_idx.
module sample_shift_reg
    import audio_pkg::*;
#(
    parameter int unsigned DATA_SIZE = AUDIO_DATA_SIZE,
    parameter int unsigned NUM_TAPS  = AUDIO_LPR_TAPS,
    parameter int unsigned IDX_W     = $clog2(NUM_TAPS)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        shift_en,
    input  logic signed [DATA_SIZE-1:0] din,
    input  logic        [IDX_W-1:0]     rd_idx,
    output logic signed [DATA_SIZE-1:0] dout
);

    logic signed [DATA_SIZE-1:0] taps_q [NUM_TAPS];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_TAPS); i++) begin
                taps_q[i] <= '0;
            end
        end else if (shift_en) begin
            taps_q[0] <= din;
            for (int i = 1; i < int'(NUM_TAPS); i++) begin
                taps_q[i] <= taps_q[i-1];
            end
        end
    end

    assign dout = taps_q[rd_idx];

endmodule

// File: rtl/audio_fir_decim.sv
// Decimating real FIR low-pass: pops DECIM samples, runs a one-tap-per-cycle MAC, writes one sample.
// Define AUDIO_FIR_VOLUME_EN to add a one-cycle VOLUME_LEVEL gain stage after the MAC.
module audio_fir_decim
    import audio_pkg::*;
#(
    parameter int unsigned                     DATA_SIZE = AUDIO_DATA_SIZE,
    parameter int unsigned                     NUM_TAPS  = AUDIO_LPR_TAPS,
    parameter int unsigned                     DECIM     = 8,
    parameter int unsigned                     QUANT     = AUDIO_QUANT,
    parameter logic [NUM_TAPS*DATA_SIZE-1:0]   COEFFS    = AUDIO_LPR_COEFFS
) (
    input  logic                        clock,
    input  logic                        reset,
    output logic                        in_rd_en,
    input  logic                        in_empty,
    input  logic signed [DATA_SIZE-1:0] in_din,
    output logic                        out_wr_en,
    input  logic                        out_full,
    output logic signed [DATA_SIZE-1:0] out_dout
);

    localparam int unsigned      TAP_W    = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam int unsigned      DEC_W    = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(NUM_TAPS - 1);
    localparam logic [DEC_W-1:0] DEC_LAST = DEC_W'(DECIM - 1);

    fir_state_e                  state_q;
    logic        [TAP_W-1:0]     tap_cnt_q;
    logic        [DEC_W-1:0]     decim_cnt_q;
    logic signed [DATA_SIZE-1:0] acc_q;
    logic signed [DATA_SIZE-1:0] acc_sum;
    logic signed [DATA_SIZE-1:0] coeff;
    logic signed [DATA_SIZE-1:0] tap_x;
    logic signed [DATA_SIZE-1:0] coeff_tab [NUM_TAPS];

    // Product truncated to DATA_SIZE bits before dequantize; no saturation anywhere.
    function automatic logic signed [DATA_SIZE-1:0] mul_dq(input logic signed [DATA_SIZE-1:0] a,
                                                           input logic signed [DATA_SIZE-1:0] b);
        logic signed [DATA_SIZE-1:0] prod;
        prod = DATA_SIZE'(a * b);
        return DATA_SIZE'(dequantize(64'(prod), QUANT));
    endfunction

    for (genvar i = 0; i < NUM_TAPS; i++) begin : g_coeff
        assign coeff_tab[i] = COEFFS[i*DATA_SIZE +: DATA_SIZE];
    end

    sample_shift_reg #(
        .DATA_SIZE (DATA_SIZE),
        .NUM_TAPS  (NUM_TAPS),
        .IDX_W     (TAP_W)
    ) u_delay_line (
        .clock    (clock),
        .reset    (reset),
        .shift_en (in_rd_en),
        .din      (in_din),
        .rd_idx   (tap_cnt_q),
        .dout     (tap_x)
    );

    always_comb begin
        coeff     = coeff_tab[tap_cnt_q];
        acc_sum   = acc_q + mul_dq(coeff, tap_x);
        in_rd_en  = (state_q == StLoad) && !in_empty;
        out_wr_en = (state_q == StWrite) && !out_full;
    end

`ifdef AUDIO_FIR_VOLUME_EN
    logic signed [DATA_SIZE-1:0] acc_vol;
    assign acc_vol = mul_dq(acc_q, DATA_SIZE'(VOLUME_LEVEL));
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StLoad;
            acc_q       <= '0;
            tap_cnt_q   <= '0;
            decim_cnt_q <= '0;
            out_dout    <= '0;
        end else begin
            unique case (state_q)
                StLoad: begin
                    if (in_rd_en) begin
                        if (decim_cnt_q == DEC_LAST) begin
                            decim_cnt_q <= '0;
                            acc_q       <= '0;
                            tap_cnt_q   <= '0;
                            state_q     <= StMac;
                        end else begin
                            decim_cnt_q <= decim_cnt_q + DEC_W'(1);
                        end
                    end
                end
                StMac: begin
                    acc_q <= acc_sum;
                    if (tap_cnt_q == TAP_LAST) begin
                        tap_cnt_q <= '0;
`ifdef AUDIO_FIR_VOLUME_EN
                        state_q   <= StVolume;
`else
                        out_dout  <= acc_sum;
                        state_q   <= StWrite;
`endif
                    end else begin
                        tap_cnt_q <= tap_cnt_q + TAP_W'(1);
                    end
                end
`ifdef AUDIO_FIR_VOLUME_EN
                StVolume: begin
                    acc_q    <= acc_vol;
                    out_dout <= acc_vol;
                    state_q  <= StWrite;
                end
`endif
                StWrite: begin
                    if (!out_full) begin
                        state_q <= StLoad;
                    end
                end
                default: state_q <= StLoad;
            endcase
        end
    end

endmodule

// File: tb/tb_audio_fir_decim.sv
// Scoreboard bench for audio_fir_decim with test taps h[i] = i+1; honours AUDIO_FIR_VOLUME_EN.
module tb_audio_fir_decim;
    import audio_pkg::*;

    localparam int NUM_TAPS = 32;
    localparam int DECIM    = 8;
    localparam int QUANT    = 10;
`ifdef AUDIO_FIR_VOLUME_EN
    localparam int LAT = NUM_TAPS + 2;
`else
    localparam int LAT = NUM_TAPS + 1;
`endif

    function automatic logic [NUM_TAPS*32-1:0] make_coeffs();
        logic [NUM_TAPS*32-1:0] c;
        for (int i = 0; i < NUM_TAPS; i++) c[i*32 +: 32] = 32'(i + 1);
        return c;
    endfunction
    localparam logic [NUM_TAPS*32-1:0] TB_COEFFS = make_coeffs();

    logic               clock = 1'b0;
    logic               reset;
    logic               in_rd_en;
    logic               in_empty;
    logic signed [31:0] in_din;
    logic               out_wr_en;
    logic               out_full;
    logic signed [31:0] out_dout;

    audio_fir_decim #(
        .DATA_SIZE (32),
        .NUM_TAPS  (NUM_TAPS),
        .DECIM     (DECIM),
        .QUANT     (QUANT),
        .COEFFS    (TB_COEFFS)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_rd_en  (in_rd_en),
        .in_empty  (in_empty),
        .in_din    (in_din),
        .out_wr_en (out_wr_en),
        .out_full  (out_full),
        .out_dout  (out_dout)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    int n_writes = 0;
    int last_write_edge = 0;
    int pop_edge = 0;
    int sb[$];
    int xm[NUM_TAPS];

    function automatic int dq(input int v);
        return (v < 0) ? -((-v) >>> QUANT) : (v >>> QUANT);
    endfunction

    function automatic int scale(input int v);
`ifdef AUDIO_FIR_VOLUME_EN
        return dq(v * int'(VOLUME_LEVEL));
`else
        return v;
`endif
    endfunction

    function automatic int model_out();
        int acc = 0;
        for (int i = 0; i < NUM_TAPS; i++) acc += dq((i + 1) * xm[i]);
        return scale(acc);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    // Offers one sample (FWFT) until popped; call and return at posedge+#1.
    task automatic feed(input int v);
        int waited = 0;
        in_din   = v;
        in_empty = 1'b0;
        @(negedge clock);
        while (!in_rd_en && waited < 200) begin
            @(negedge clock);
            waited++;
        end
        check("pop", 32'(in_rd_en), 32'd1);
        pop_edge = cyc + 1;
        @(posedge clock);
        #1;
        in_empty = 1'b1;
        for (int i = NUM_TAPS - 1; i > 0; i--) xm[i] = xm[i-1];
        xm[0] = v;
    endtask

    task automatic wait_writes(input int target);
        int w = 0;
        while (n_writes < target && w < 400) begin
            @(negedge clock);
            #1;
            w++;
        end
        check("write_count", n_writes, target);
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_empty = 1'b1;
        out_full = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        for (int i = 0; i < NUM_TAPS; i++) xm[i] = 0;
    endtask

    // Output monitor: every write pops the scoreboard.
    initial begin
        int exp_v;
        forever begin
            @(negedge clock);
            if (reset === 1'b0 && out_wr_en === 1'b1) begin
                n_writes++;
                last_write_edge = cyc + 1;
                if (sb.size() == 0) begin
                    check("unexpected_write", 32'(out_wr_en), 32'd0);
                end else begin
                    exp_v = sb.pop_front();
                    check("out_dout", out_dout, exp_v);
                end
            end
        end
    end

    initial begin
        #600000;
        $error("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        int writes_before;
        reset    = 1'b1;
        in_empty = 1'b1;
        out_full = 1'b0;
        in_din   = '0;
        for (int i = 0; i < NUM_TAPS; i++) xm[i] = 0;
        repeat (3) @(negedge clock);
        check("rst_out_dout", out_dout, 32'd0);
        check("rst_out_wr_en", 32'(out_wr_en), 32'd0);
        check("rst_in_rd_en", 32'(in_rd_en), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("idle_out_wr_en", 32'(out_wr_en), 32'd0);
        check("idle_out_dout", out_dout, 32'd0);
        @(posedge clock);
        #1;

        // Impulse: outputs are h[8k+7] = 8, 16, 24, 32 then 0.
        feed(1024);
        repeat (DECIM - 1) feed(0);
        sb.push_back(scale(8));
        p = pop_edge;
        wait_writes(1);
        check("latency_impulse", last_write_edge - p, LAT);
        for (int k = 1; k < 5; k++) begin
            repeat (DECIM) feed(0);
            sb.push_back(scale((k < 4) ? 8 * (k + 1) : 0));
        end
        wait_writes(5);

        // Constant -1: each small negative product dequantizes toward zero.
        repeat (DECIM) feed(-1);
        sb.push_back(0);
        wait_writes(6);

        // DC -1024 from a clean line: partial sums of h ramp to the full sum.
        do_reset();
        sb.push_back(scale(-36));
        repeat (DECIM) feed(-1024);
        sb.push_back(scale(-136));
        repeat (DECIM) feed(-1024);
        sb.push_back(scale(-300));
        repeat (DECIM) feed(-1024);
        sb.push_back(scale(-528));
        repeat (DECIM) feed(-1024);
        sb.push_back(scale(-528));
        repeat (DECIM) feed(-1024);
        wait_writes(11);

        // Backpressure: hold WRITE for 50 cycles with data offered upstream.
        repeat (DECIM) feed(-1024);
        sb.push_back(scale(-528));
        out_full = 1'b1;
        repeat (LAT - 1) begin
            @(posedge clock);
            #1;
        end
        in_din   = 777;
        in_empty = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            check("bp_out_wr_en", 32'(out_wr_en), 32'd0);
            check("bp_in_rd_en", 32'(in_rd_en), 32'd0);
            check("bp_out_dout", out_dout, scale(-528));
        end
        @(posedge clock);
        #1;
        in_empty = 1'b1;
        out_full = 1'b0;
        #1;
        check("bp_release_wr_en", 32'(out_wr_en), 32'd1);
        wait_writes(12);

        // Reset at tap 10 of the MAC: partial result dropped, no write.
        repeat (DECIM) feed(500);
        repeat (10) begin
            @(posedge clock);
            #1;
        end
        writes_before = n_writes;
        reset = 1'b1;
        #1;
        check("mid_rst_out_dout", out_dout, 32'd0);
        check("mid_rst_out_wr_en", 32'(out_wr_en), 32'd0);
        check("mid_rst_in_rd_en", 32'(in_rd_en), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        for (int i = 0; i < NUM_TAPS; i++) xm[i] = 0;
        repeat (60) begin
            @(posedge clock);
            #1;
        end
        check("mid_rst_no_write", n_writes, writes_before);
        repeat (DECIM) feed(-1024);
        sb.push_back(scale(-36));
        wait_writes(13);

        // Random samples with random input gaps against the reference model.
        do_reset();
        for (int g = 0; g < 4; g++) begin
            for (int s = 0; s < DECIM; s++) begin
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clock);
                    #1;
                end
                feed(int'($urandom_range(0, 200000)) - 100000);
            end
            sb.push_back(model_out());
            if (g == 0) begin
                p = pop_edge;
                wait_writes(14);
                check("latency_gaps", last_write_edge - p, LAT);
            end
        end
        wait_writes(17);
        check("scoreboard_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
